// File: rtl/awgn_pkg.sv
// Shared types and constants for the AWGN stream controller and its FIFO.
package awgn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_WARM  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int NUM_SEEDS    = 6;
  localparam int SAMPLE_W_DEF = 16;

  localparam logic [31:0] SEED1_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] SEED2_DEF = 32'hFDFD_FDFD;
  localparam logic [31:0] SEED3_DEF = 32'hEFEF_EFEF;
  localparam logic [31:0] SEED4_DEF = 32'hFEDA_FEDA;
  localparam logic [31:0] SEED5_DEF = 32'hFFFA_FFFA;
  localparam logic [31:0] SEED6_DEF = 32'hFDEA_FDEA;

  // Power-on value of seed register idx (0 -> s1 ... 5 -> s6).
  function automatic logic [31:0] seed_default(input int idx);
    case (idx)
      0:       return SEED1_DEF;
      1:       return SEED2_DEF;
      2:       return SEED3_DEF;
      3:       return SEED4_DEF;
      4:       return SEED5_DEF;
      5:       return SEED6_DEF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/awgn_pair_fifo.sv
// Synchronous FIFO for {x0,x1} sample pairs. The head is held in a register so
// the output is stable while stalled; a push into an empty FIFO is visible on
// dout the following cycle. A push is accepted when not full or when a pop
// frees a slot in the same cycle.
module awgn_pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] dout_r;
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [AW:0]      rd_next_s;
  logic [WIDTH-1:0] head_next_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout  = dout_r;

  // Effective push/pop and the value that will sit at the head next cycle.
  always_comb begin
    rd_en_s   = pop & ~empty;
    wr_en_s   = push & (~full | rd_en_s);
    rd_next_s = rd_ptr_r + {{AW{1'b0}}, rd_en_s};
    if (wr_en_s && (rd_next_s == wr_ptr_r)) begin
      head_next_s = din;
    end else begin
      head_next_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      dout_r   <= {WIDTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_next_s;
      dout_r   <= head_next_s;
    end
  end

endmodule

// File: rtl/awgn_stream_ctrl.sv
// Sequencer/streamer for the Box-Muller AWGN core: owns the seeds and the core
// reset, hides pipeline warm-up, and streams a burst of {x0,x1} pairs. The core
// cannot stall, so pairs arriving while the FIFO is full are dropped and counted.
module awgn_stream_ctrl
  import awgn_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH   = 8,
  parameter int CORE_RST_CYC = 2,
  parameter int WARMUP_CYC   = 12,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  input  logic                  start,
  input  logic [CNT_W-1:0]      burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      overflow_cnt,
  output logic                  core_reset,
  output logic [31:0]           s1,
  output logic [31:0]           s2,
  output logic [31:0]           s3,
  output logic [31:0]           s4,
  output logic [31:0]           s5,
  output logic [31:0]           s6,
  input  logic [SAMPLE_W-1:0]   core_x0,
  input  logic [SAMPLE_W-1:0]   core_x1,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*SAMPLE_W-1:0] m_data
);

  localparam logic [15:0] CRST_LAST = 16'(CORE_RST_CYC - 1);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYC - 1);

  state_t             state_r;
  logic [15:0]        wait_cnt_r;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   cap_cnt_r;
  logic [CNT_W-1:0]   ovf_cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               core_reset_r;
  logic [31:0]        seed_r [NUM_SEEDS];
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               cfg_wr_s;

  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow_cnt = ovf_cnt_r;
  assign core_reset   = core_reset_r;
  assign m_valid      = ~fifo_empty_s;
  assign s1           = seed_r[0];
  assign s2           = seed_r[1];
  assign s3           = seed_r[2];
  assign s4           = seed_r[3];
  assign s5           = seed_r[4];
  assign s6           = seed_r[5];

  // Handshake decode: pop on valid&ready, capture every RUN cycle that has room.
  always_comb begin
    pop_s    = ~fifo_empty_s & m_ready;
    cfg_wr_s = cfg_we & (state_r == ST_IDLE) & ~busy_r;
    if ((state_r == ST_RUN) && (!fifo_full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Seed register file; writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEEDS; i++) begin
        seed_r[i] <= seed_default(i);
      end
    end else if (cfg_wr_s) begin
      case (cfg_addr)
        3'd0:    seed_r[0] <= cfg_wdata;
        3'd1:    seed_r[1] <= cfg_wdata;
        3'd2:    seed_r[2] <= cfg_wdata;
        3'd3:    seed_r[3] <= cfg_wdata;
        3'd4:    seed_r[4] <= cfg_wdata;
        3'd5:    seed_r[5] <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Burst sequencer with registered status and core-reset outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 16'd0;
      len_r        <= {CNT_W{1'b0}};
      cap_cnt_r    <= {CNT_W{1'b0}};
      ovf_cnt_r    <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_reset_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          core_reset_r <= 1'b1;
          // busy_r is still high during the done cycle, which blocks a start there
          if (start && !busy_r) begin
            busy_r     <= 1'b1;
            len_r      <= burst_len;
            cap_cnt_r  <= {CNT_W{1'b0}};
            ovf_cnt_r  <= {CNT_W{1'b0}};
            wait_cnt_r <= 16'd0;
            if (burst_len == {CNT_W{1'b0}}) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_CRST;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CRST: begin
          if (wait_cnt_r == CRST_LAST) begin
            wait_cnt_r   <= 16'd0;
            core_reset_r <= 1'b0;
            state_r      <= ST_WARM;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_WARM: begin
          if (wait_cnt_r == WARM_LAST) begin
            wait_cnt_r <= 16'd0;
            state_r    <= ST_RUN;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_RUN: begin
          if (push_s) begin
            cap_cnt_r <= cap_cnt_r + CNT_W'(1);
            if ((cap_cnt_r + CNT_W'(1)) == len_r) begin
              core_reset_r <= 1'b1;
              state_r      <= ST_DRAIN;
            end
          end else if (ovf_cnt_r != {CNT_W{1'b1}}) begin
            ovf_cnt_r <= ovf_cnt_r + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (fifo_empty_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          core_reset_r <= 1'b1;
        end
      endcase
    end
  end

  awgn_pair_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({core_x0, core_x1}),
    .dout  (m_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_awgn_stream_ctrl.sv
// Directed bench for awgn_stream_ctrl: seed table plus burst corner sequences,
// with a counter-based stand-in for the AWGN core.
module tb_awgn_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_wdata = 32'h0;
  logic        start = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic        busy, done, core_reset, m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] overflow_cnt;
  logic [31:0] s1, s2, s3, s4, s5, s6;
  logic [15:0] core_x0, core_x1;
  logic [31:0] m_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  awgn_stream_ctrl #(
    .SAMPLE_W(16), .FIFO_DEPTH(8), .CORE_RST_CYC(2), .WARMUP_CYC(12), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .overflow_cnt(overflow_cnt), .core_reset(core_reset),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6),
    .core_x0(core_x0), .core_x1(core_x1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  // Core stand-in: sample index counts cycles since core_reset fell.
  logic [15:0] core_cnt = 16'd0;
  always @(posedge clk) begin
    if (core_reset) core_cnt <= 16'd0;
    else            core_cnt <= core_cnt + 16'd1;
  end
  assign core_x0 = 16'hA000 + core_cnt;
  assign core_x1 = 16'h5000 + core_cnt;

  logic [31:0] seed_obs [6];
  assign seed_obs[0] = s1;
  assign seed_obs[1] = s2;
  assign seed_obs[2] = s3;
  assign seed_obs[3] = s4;
  assign seed_obs[4] = s5;
  assign seed_obs[5] = s6;

  // Stream / status monitor sampled on the falling edge.
  logic [31:0] pop_mem [256];
  int          pop_n = 0;
  int          done_cnt = 0;
  int          low_cnt = 0;
  int          valid_cnt = 0;
  int          unstable = 0;
  int          stall_seen = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = 32'h0;
  always @(negedge clk) begin
    if (m_valid && m_ready && pop_n < 256) begin
      pop_mem[pop_n] <= m_data;
      pop_n <= pop_n + 1;
    end
    if (done)        done_cnt <= done_cnt + 1;
    if (!core_reset) low_cnt <= low_cnt + 1;
    if (m_valid)     valid_cnt <= valid_cnt + 1;
    if (stall_prev && m_valid && (m_data !== stall_data)) unstable <= unstable + 1;
    if (m_valid && !m_ready) stall_seen <= stall_seen + 1;
    stall_prev <= m_valid && !m_ready;
    stall_data <= m_data;
  end

  function automatic logic [31:0] pair(input int c);
    return {16'hA000 + 16'(c), 16'h5000 + 16'(c)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_start(input logic [15:0] len);
    @(negedge clk);
    start = 1'b1;
    burst_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    int          chk_idx;
    logic [31:0] exp;
  } seed_vec_t;

  seed_vec_t vecs [8];
  int bp, bd, bl, bv;
  logic [31:0] exp_defaults [6];
  int bad;

  initial begin
    exp_defaults[0] = 32'hFFFFFFFF; exp_defaults[1] = 32'hFDFDFDFD;
    exp_defaults[2] = 32'hEFEFEFEF; exp_defaults[3] = 32'hFEDAFEDA;
    exp_defaults[4] = 32'hFFFAFFFA; exp_defaults[5] = 32'hFDEAFDEA;
    vecs[0] = '{1'b1, 3'd0, 32'h11111111, 0, 32'h11111111};
    vecs[1] = '{1'b1, 3'd5, 32'h66666666, 5, 32'h66666666};
    vecs[2] = '{1'b0, 3'd1, 32'hDEADBEEF, 1, 32'hFDFDFDFD};
    vecs[3] = '{1'b1, 3'd6, 32'hDEADBEEF, 0, 32'h11111111};
    vecs[4] = '{1'b1, 3'd7, 32'hDEADBEEF, 5, 32'h66666666};
    vecs[5] = '{1'b1, 3'd1, 32'h22222222, 1, 32'h22222222};
    vecs[6] = '{1'b1, 3'd0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF};
    vecs[7] = '{1'b1, 3'd2, 32'h12345678, 2, 32'h12345678};

    // 1: reset and idle behaviour
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_reset !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) bad++;
    end
    chk("idle_outputs", 64'(bad), 64'd0);
    for (int i = 0; i < 6; i++) chk("seed_default", 64'(seed_obs[i]), 64'(exp_defaults[i]));
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_overflow", 64'(overflow_cnt), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // seed write table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].data;
      @(posedge clk);
      #1 cfg_we = 1'b0;
      chk("seed_table", 64'(seed_obs[vecs[i].chk_idx]), 64'(vecs[i].exp));
    end

    // 2: four-pair burst with free-flowing sink
    m_ready = 1'b1;
    bp = pop_n; bd = done_cnt; bl = low_cnt;
    do_start(16'd4);
    wait_done(200);
    repeat (3) @(posedge clk);
    #1;
    chk("b4_pops", 64'(pop_n - bp), 64'd4);
    for (int i = 0; i < 4; i++) chk("b4_data", 64'(pop_mem[bp+i]), 64'(pair(12 + i)));
    chk("b4_done_once", 64'(done_cnt - bd), 64'd1);
    chk("b4_core_reset_low", 64'(low_cnt - bl), 64'd16);
    chk("b4_overflow", 64'(overflow_cnt), 64'd0);
    chk("b4_s3", 64'(s3), 64'h12345678);
    chk("b4_busy_after", 64'(busy), 64'd0);

    // 3: stalled sink, overflow, then release
    m_ready = 1'b0;
    bp = pop_n; bd = done_cnt;
    do_start(16'd20);
    repeat (26) @(posedge clk);
    #1;
    chk("b20_stall_valid", 64'(m_valid), 64'd1);
    chk("b20_stall_head", 64'(m_data), 64'(pair(12)));
    @(posedge clk);
    #1 m_ready = 1'b1;
    chk("b20_overflow_at_release", 64'(overflow_cnt), 64'd5);
    wait_done(200);
    repeat (2) @(posedge clk);
    #1;
    chk("b20_pops", 64'(pop_n - bp), 64'd20);
    for (int i = 0; i < 20; i++)
      chk("b20_data", 64'(pop_mem[bp+i]), 64'(pair(i < 8 ? 12 + i : 17 + i)));
    chk("b20_overflow_final", 64'(overflow_cnt), 64'd5);
    chk("b20_stable_while_stalled", 64'(unstable), 64'd0);
    chk("b20_stall_seen", 64'(stall_seen > 0), 64'd1);
    chk("b20_done_once", 64'(done_cnt - bd), 64'd1);

    // 4: zero-length burst
    bl = low_cnt; bv = valid_cnt; bd = done_cnt;
    do_start(16'd0);
    @(negedge clk);
    chk("b0_c1_done", 64'(done), 64'd0);
    chk("b0_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("b0_c2_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("b0_c3_busy", 64'(busy), 64'd0);
    chk("b0_c3_done", 64'(done), 64'd0);
    chk("b0_no_core_release", 64'(low_cnt - bl), 64'd0);
    chk("b0_no_valid", 64'(valid_cnt - bv), 64'd0);
    chk("b0_done_once", 64'(done_cnt - bd), 64'd1);

    // 5: cfg write and start while busy are ignored
    bp = pop_n; bd = done_cnt;
    do_start(16'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 32'hAAAAAAAA;
    start = 1'b1; burst_len = 16'd9;
    @(posedge clk);
    #1 cfg_we = 1'b0; start = 1'b0;
    wait_done(200);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_s3_kept", 64'(s3), 64'h12345678);
    chk("busy_pops", 64'(pop_n - bp), 64'd3);
    for (int i = 0; i < 3; i++) chk("busy_data", 64'(pop_mem[bp+i]), 64'(pair(12 + i)));
    chk("busy_done_once", 64'(done_cnt - bd), 64'd1);
    chk("busy_idle_after", 64'(busy), 64'd0);

    // 6: reset during RUN with three pairs queued
    m_ready = 1'b0;
    do_start(16'd8);
    repeat (17) @(posedge clk);
    #1;
    chk("abort_queued_valid", 64'(m_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_core_reset", 64'(core_reset), 64'd1);
    chk("abort_m_data", 64'(m_data), 64'd0);
    chk("abort_s3_default", 64'(s3), 64'hEFEFEFEF);
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    bp = pop_n; bd = done_cnt;
    do_start(16'd2);
    wait_done(200);
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_pops", 64'(pop_n - bp), 64'd2);
    for (int i = 0; i < 2; i++) chk("post_abort_data", 64'(pop_mem[bp+i]), 64'(pair(12 + i)));
    chk("post_abort_done_once", 64'(done_cnt - bd), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
